// File: rtl/icache_responder.sv
// Direct-mapped read-only instruction cache answering fetch port A, filling 128-bit lines from pmem.
// Optional hit/miss statistics counters are enabled by defining ICACHE_STATS_EN.
module icache_responder #(
    parameter int NUM_SETS = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         read_a,
    input  logic [15:0]  address_a,
    output logic         resp_a,
    output logic [15:0]  rdata_a,
    input  logic         flush,
    output logic         pmem_read,
    output logic [15:0]  pmem_address,
    input  logic         pmem_resp,
    input  logic [127:0] pmem_rdata
`ifdef ICACHE_STATS_EN
    ,
    input  logic         stats_reset,
    output logic [15:0]  hit_count,
    output logic [15:0]  miss_count
`endif
);

    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int TAG_W = 12 - IDX_W;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [15:0]             miss_addr_q, miss_addr_d;
    logic [NUM_SETS-1:0]     valid_q, valid_d;
    logic [127:0]            data_q [NUM_SETS];
    logic [TAG_W-1:0]        tag_q  [NUM_SETS];

    logic [IDX_W-1:0]        req_idx_s;
    logic [TAG_W-1:0]        req_tag_s;
    logic [2:0]              req_off_s;
    logic [IDX_W-1:0]        fill_idx_s;
    logic [TAG_W-1:0]        fill_tag_s;
    logic [127:0]            req_line_s;
    logic                    hit_s;
    logic                    fill_we_s;
    logic                    miss_s;

    assign req_off_s  = address_a[3:1];
    assign req_idx_s  = address_a[3+IDX_W:4];
    assign req_tag_s  = address_a[15:4+IDX_W];
    assign fill_idx_s = miss_addr_q[3+IDX_W:4];
    assign fill_tag_s = miss_addr_q[15:4+IDX_W];
    assign req_line_s = data_q[req_idx_s];
    assign hit_s      = (state_q == ST_IDLE) && read_a && valid_q[req_idx_s]
                        && (tag_q[req_idx_s] == req_tag_s);

    // Next-state, fill control and port outputs; flush overrides any valid bit set by a fill.
    always_comb begin
        state_d      = state_q;
        miss_addr_d  = miss_addr_q;
        valid_d      = valid_q;
        resp_a       = 1'b0;
        rdata_a      = 16'h0000;
        pmem_read    = 1'b0;
        pmem_address = 16'h0000;
        fill_we_s    = 1'b0;
        miss_s       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (hit_s) begin
                    resp_a  = 1'b1;
                    rdata_a = req_line_s[{req_off_s, 4'b0000} +: 16];
                end else if (read_a) begin
                    miss_s      = 1'b1;
                    miss_addr_d = {address_a[15:4], 4'b0000};
                    state_d     = ST_FILL;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FILL: begin
                pmem_read    = 1'b1;
                pmem_address = miss_addr_q;
                if (pmem_resp) begin
                    fill_we_s           = 1'b1;
                    valid_d[fill_idx_s] = 1'b1;
                    state_d             = ST_IDLE;
                end else begin
                    state_d = ST_FILL;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (flush) begin
            valid_d = '0;
        end else begin
            valid_d = valid_d;
        end
    end

    // State, miss address and valid bits; reset abandons any fill in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            miss_addr_q <= 16'h0000;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
            valid_q     <= valid_d;
        end
    end

    // Line data and tag storage, written only when a fill completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SETS; i++) begin
                data_q[i] <= 128'h0;
                tag_q[i]  <= '0;
            end
        end else if (fill_we_s) begin
            data_q[fill_idx_s] <= pmem_rdata;
            tag_q[fill_idx_s]  <= fill_tag_s;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [15:0] hit_count_q, hit_count_d;
    logic [15:0] miss_count_q, miss_count_d;

    // Saturating counters; stats_reset beats a same-cycle increment.
    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (stats_reset) begin
            hit_count_d  = 16'h0000;
            miss_count_d = 16'h0000;
        end else begin
            if (resp_a && (hit_count_q != 16'hFFFF)) begin
                hit_count_d = hit_count_q + 16'h0001;
            end else begin
                hit_count_d = hit_count_q;
            end
            if (miss_s && (miss_count_q != 16'hFFFF)) begin
                miss_count_d = miss_count_q + 16'h0001;
            end else begin
                miss_count_d = miss_count_q;
            end
        end
    end

    // Statistics counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count_q  <= 16'h0000;
            miss_count_q <= 16'h0000;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_icache_responder.sv
// Table-driven bench for icache_responder (NUM_SETS=8) plus a hand-written reset-during-fill sequence.
module tb_icache_responder;

    logic         clk;
    logic         rst;
    logic         read_a;
    logic [15:0]  address_a;
    logic         resp_a;
    logic [15:0]  rdata_a;
    logic         flush;
    logic         pmem_read;
    logic [15:0]  pmem_address;
    logic         pmem_resp;
    logic [127:0] pmem_rdata;
`ifdef ICACHE_STATS_EN
    logic         stats_reset;
    logic [15:0]  hit_count;
    logic [15:0]  miss_count;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    icache_responder #(.NUM_SETS(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .read_a       (read_a),
        .address_a    (address_a),
        .resp_a       (resp_a),
        .rdata_a      (rdata_a),
        .flush        (flush),
        .pmem_read    (pmem_read),
        .pmem_address (pmem_address),
        .pmem_resp    (pmem_resp),
        .pmem_rdata   (pmem_rdata)
`ifdef ICACHE_STATS_EN
        ,
        .stats_reset  (stats_reset),
        .hit_count    (hit_count),
        .miss_count   (miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic [15:0] addr;
        logic        fl;
        logic        presp;
        logic [15:0] lbase;
        logic        e_resp;
        logic [15:0] e_rdata;
        logic        e_pread;
        logic [15:0] e_paddr;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [127:0] mkline(input logic [15:0] base);
        logic [127:0] l;
        for (int k = 0; k < 8; k++) l[16*k +: 16] = base + 16'(k);
        return l;
    endfunction

    task automatic add(input logic rd, input logic [15:0] addr, input logic fl, input logic presp,
                       input logic [15:0] lbase, input logic e_resp, input logic [15:0] e_rdata,
                       input logic e_pread, input logic [15:0] e_paddr);
        vec_t v;
        v.rd = rd; v.addr = addr; v.fl = fl; v.presp = presp; v.lbase = lbase;
        v.e_resp = e_resp; v.e_rdata = e_rdata; v.e_pread = e_pread; v.e_paddr = e_paddr;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic chk_all(input string tag, input logic e_resp, input logic [15:0] e_rdata,
                           input logic e_pread, input logic [15:0] e_paddr);
        chk({tag, " resp_a"},       {15'd0, resp_a},    {15'd0, e_resp});
        chk({tag, " rdata_a"},      rdata_a,            e_rdata);
        chk({tag, " pmem_read"},    {15'd0, pmem_read}, {15'd0, e_pread});
        chk({tag, " pmem_address"}, pmem_address,       e_paddr);
    endtask

    initial begin
        rst = 1'b1; read_a = 1'b0; address_a = 16'h0000; flush = 1'b0;
        pmem_resp = 1'b0; pmem_rdata = 128'h0;
`ifdef ICACHE_STATS_EN
        stats_reset = 1'b0;
`endif
        // rd addr fl presp lbase | resp rdata pread paddr
        add(1'b1, 16'h0040, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        add(1'b1, 16'h0040, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0040);
        add(1'b1, 16'h0040, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0040);
        add(1'b1, 16'h0040, 1'b0, 1'b1, 16'h1000, 1'b0, 16'h0000, 1'b1, 16'h0040);
        add(1'b1, 16'h0040, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h1000, 1'b0, 16'h0000);
        add(1'b1, 16'h004E, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h1007, 1'b0, 16'h0000);
        add(1'b0, 16'h004E, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        add(1'b1, 16'h00C0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        add(1'b1, 16'h00C0, 1'b0, 1'b1, 16'h2000, 1'b0, 16'h0000, 1'b1, 16'h00C0);
        add(1'b1, 16'h00C2, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h2001, 1'b0, 16'h0000);
        add(1'b1, 16'h0040, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        add(1'b1, 16'h0040, 1'b0, 1'b1, 16'h1000, 1'b0, 16'h0000, 1'b1, 16'h0040);
        add(1'b1, 16'h0040, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h1000, 1'b0, 16'h0000);
        add(1'b1, 16'h0040, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h1000, 1'b0, 16'h0000);
        add(1'b1, 16'h0040, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        add(1'b1, 16'h2000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0040);
        add(1'b1, 16'h2000, 1'b0, 1'b1, 16'h1000, 1'b0, 16'h0000, 1'b1, 16'h0040);
        add(1'b1, 16'h2000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        add(1'b1, 16'h2000, 1'b0, 1'b1, 16'h3000, 1'b0, 16'h0000, 1'b1, 16'h2000);
        add(1'b1, 16'h2006, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h3003, 1'b0, 16'h0000);
        add(1'b1, 16'h0040, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h1000, 1'b0, 16'h0000);
        add(1'b1, 16'h00C0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        add(1'b1, 16'h00C0, 1'b1, 1'b1, 16'h2000, 1'b0, 16'h0000, 1'b1, 16'h00C0);
        add(1'b1, 16'h00C0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        add(1'b1, 16'h00C0, 1'b0, 1'b1, 16'h2000, 1'b0, 16'h0000, 1'b1, 16'h00C0);
        add(1'b1, 16'h2000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        add(1'b1, 16'h2000, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h2000);
        add(1'b1, 16'h2000, 1'b0, 1'b1, 16'h3000, 1'b0, 16'h0000, 1'b1, 16'h2000);
        add(1'b1, 16'h2000, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h3000, 1'b0, 16'h0000);
        add(1'b1, 16'h00C4, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        add(1'b1, 16'h00C4, 1'b0, 1'b1, 16'h2000, 1'b0, 16'h0000, 1'b1, 16'h00C0);
        add(1'b1, 16'h00C4, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h2002, 1'b0, 16'h0000);

        repeat (2) @(negedge clk);
        #2;
        chk_all("reset", 1'b0, 16'h0000, 1'b0, 16'h0000);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            if (i != 0) @(negedge clk);
            read_a     = vecs[i].rd;
            address_a  = vecs[i].addr;
            flush      = vecs[i].fl;
            pmem_resp  = vecs[i].presp;
            pmem_rdata = vecs[i].presp ? mkline(vecs[i].lbase) : 128'h0;
            #2;
            chk_all($sformatf("vec%0d", i), vecs[i].e_resp, vecs[i].e_rdata,
                    vecs[i].e_pread, vecs[i].e_paddr);
`ifdef ICACHE_STATS_EN
            if (i == 6) begin
                chk("hit_count", hit_count, 16'd2);
                chk("miss_count", miss_count, 16'd1);
            end
`endif
        end

        // Reset in the middle of a fill, then a stray pmem_resp.
        @(negedge clk);
        read_a = 1'b1; address_a = 16'h0050; flush = 1'b0; pmem_resp = 1'b0; pmem_rdata = 128'h0;
        #2;
        chk_all("rst_miss", 1'b0, 16'h0000, 1'b0, 16'h0000);
        @(negedge clk);
        #2;
        chk_all("rst_fill", 1'b0, 16'h0000, 1'b1, 16'h0050);
        rst = 1'b1;
        #1;
        chk_all("rst_abort", 1'b0, 16'h0000, 1'b0, 16'h0000);
        @(negedge clk);
        rst = 1'b0; read_a = 1'b0; pmem_resp = 1'b1; pmem_rdata = mkline(16'h5000);
        #2;
        chk_all("stray_resp", 1'b0, 16'h0000, 1'b0, 16'h0000);
        @(negedge clk);
        pmem_resp = 1'b0; pmem_rdata = 128'h0; read_a = 1'b1; address_a = 16'h0050;
        #2;
        chk_all("post_rst_miss", 1'b0, 16'h0000, 1'b0, 16'h0000);
        @(negedge clk);
        pmem_resp = 1'b1; pmem_rdata = mkline(16'h4000);
        #2;
        chk_all("post_rst_fill", 1'b0, 16'h0000, 1'b1, 16'h0050);
        @(negedge clk);
        pmem_resp = 1'b0; pmem_rdata = 128'h0; address_a = 16'h00C4;
        #2;
        chk_all("old_line_gone", 1'b0, 16'h0000, 1'b0, 16'h0000);
        @(negedge clk);
        #2;
        chk_all("old_line_refill", 1'b0, 16'h0000, 1'b1, 16'h00C0);
        @(negedge clk);
        address_a = 16'h0054; pmem_resp = 1'b0;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        @(negedge clk);
        read_a = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
